instruction_memory_pipelined: RTL and testbench
===============================================

Name: instruction_memory_pipelined

Overview:
Parametrised successor to the combinational instruction ROM. Byte-addressed, little-endian instruction memory with a registered, fixed-latency fetch port using a req/ready/valid handshake, plus a word-wide byte-enabled program-load write port. Misaligned and out-of-range fetches are reported to the fetch stage as fault codes. Sits between the PC/fetch stage and decode; the load port is driven by the bootloader/testbench.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; power of two, minimum 16.
ADDR_W, 32, width of the fetch and load address ports.
READ_LATENCY, 1, cycles from an accepted request to fetch_valid_o; legal range 1..4.
RESET_INSTR, 32'h00000013, value of instruction_o while reset is asserted and for faulted fetches (NOP).

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  asynchronous, active-high reset
fetch_req_i  in  1  fetch request
fetch_addr_i  in  ADDR_W  byte address of the instruction
fetch_ready_o  out  1  high when a request can be accepted this cycle
fetch_valid_o  out  1  one-cycle pulse; instruction_o and fault_o are valid
instruction_o  out  32  {mem[a+3],mem[a+2],mem[a+1],mem[a]}
fault_o  out  2  00 ok, 01 misaligned, 10 out of range, 11 both
load_we_i  in  1  program-load write enable
load_addr_i  in  ADDR_W  byte address; bits [1:0] ignored (word aligned)
load_data_i  in  32  write data, little-endian byte lanes
load_be_i  in  4  byte enables; bit n writes byte n of the word

Behaviour:
- Storage: DEPTH_BYTES x 8 array, initialised to 0 at time zero. Storage is not cleared by reset.
- Reset (asynchronous): state goes to IDLE. fetch_ready_o=0 while rst_i is high and 1 in the first cycle after release. fetch_valid_o=0, instruction_o=RESET_INSTR, fault_o=00. An in-flight fetch is discarded and produces no valid pulse.
- FSM:
  - IDLE: ready=1. On fetch_req_i&&ready, the request is accepted and the FSM moves to BUSY, with the latency counter loaded to READ_LATENCY-1.
  - BUSY: ready=0 and the counter decrements each cycle. When the counter is 0, the next edge asserts fetch_valid_o for exactly one cycle and returns to IDLE.
  - With READ_LATENCY=1, valid rises on the edge after acceptance.
  - One request is outstanding at a time, so throughput is 1 per READ_LATENCY+1 cycles. A request raised while ready=0 is ignored; the requester must hold it.
- Sampling: the address, fault classification and memory word are all sampled in the acceptance cycle. Data is carried through the latency stages unchanged.
- Fault classification:
  - Misaligned: fetch_addr_i[1:0]!=0.
  - Out of range: fetch_addr_i > DEPTH_BYTES-4, computed at ADDR_W+1 bits so there is no wrap.
  - On any fault, instruction_o=RESET_INSTR and no array read occurs.
- instruction_o and fault_o hold their last values between valid pulses.
- Load port:
  - Writes on the edge when load_we_i=1, independent of the FSM; byte n is written iff load_be_i[n].
  - A load with load_addr_i>DEPTH_BYTES-4 is dropped silently.
- Same-cycle load and fetch acceptance to the same word: the fetch returns the old data (read-before-write). A load to the fetched word while that fetch is in BUSY does not alter the returned instruction.
- Reset mid-write: a write on an edge at which rst_i is high is suppressed.

Test Plan:
- Reset and single fetch:
  - Release reset, with READ_LATENCY=1.
  - Load 0x00402103 at 0x0 with be=1111, then fetch 0x0.
  - Required: valid one cycle after acceptance, instruction_o=0x00402103, fault=00, ready low for exactly 1 cycle.
- Byte enables:
  - Load 0xAABBCCDD at 0x18 with be=1111, then 0x11223344 with be=0101.
  - Fetch 0x18. Required: 0xAA22CC44.
- Faults (DEPTH_BYTES=1024):
  - Fetch 0x2. Required: fault=01, instruction_o=0x00000013.
  - Fetch 0x400. Required: fault=10.
  - Fetch 0x3FE. Required: fault=11.
  - Fetch 0x3FC. Required: fault=00.
- Latency sweep:
  - READ_LATENCY=1..4, back-to-back requests held high.
  - Required: valid exactly READ_LATENCY cycles after each acceptance, and one acceptance every READ_LATENCY+1 cycles.
- Collision:
  - Word 0x8 holds 0x11111111. Write 0x22222222 to 0x8 in the same cycle the fetch of 0x8 is accepted.
  - Required: returns 0x11111111, and the next fetch returns 0x22222222.
- Reset mid-fetch:
  - READ_LATENCY=3, assert rst_i one cycle after acceptance.
  - Required: no valid pulse, instruction_o=0x00000013, ready=1 in the first cycle after release, memory contents preserved.

Source files
------------

// File: rtl/instruction_memory_pipelined.sv
// ============================================================================
// Module   : instruction_memory_pipelined
// Brief    : Byte-addressed little-endian instruction memory with a fixed-latency
//            req/ready/valid fetch port, fault reporting and a byte-enabled load port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_memory_pipelined #(
  parameter int          DEPTH_BYTES  = 1024,
  parameter int          ADDR_W       = 32,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] RESET_INSTR  = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic              fetch_valid_o,
  output logic [31:0]       instruction_o,
  output logic [1:0]        fault_o,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i,
  input  logic [3:0]        load_be_i
);

  localparam int               IDX_W          = $clog2(DEPTH_BYTES);
  localparam int               WIDX_W         = IDX_W - 2;
  localparam int               CNT_W          = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W:0]  LAST_WORD_ADDR = (ADDR_W + 1)'(DEPTH_BYTES - 4);
  localparam logic [CNT_W-1:0] CNT_LOAD       = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready;
  logic              accept;
  logic              fire;
  logic [31:0]       cap_instr;
  logic [1:0]        cap_fault;

  logic              fetch_misaligned;
  logic              fetch_out_of_range;
  logic              load_out_of_range;
  logic [WIDX_W-1:0] fetch_widx;
  logic [WIDX_W-1:0] load_widx;
  logic [31:0]       rd_word;
  logic              wr_en;
  logic              unused_load_lsbs;

  // Range checks are done one bit wider than the address so large addresses cannot wrap.
  assign fetch_misaligned   = |fetch_addr_i[1:0];
  assign fetch_out_of_range = {1'b0, fetch_addr_i} > LAST_WORD_ADDR;
  assign load_out_of_range  = {1'b0, load_addr_i} > LAST_WORD_ADDR;
  assign fetch_widx         = fetch_addr_i[IDX_W-1:2];
  assign load_widx          = load_addr_i[IDX_W-1:2];
  assign unused_load_lsbs   = ^load_addr_i[1:0];

  assign wr_en = load_we_i & ~rst_i & ~load_out_of_range;

  always_comb begin
    rd_word = RESET_INSTR;
    if (!fetch_misaligned && !fetch_out_of_range) begin
      for (int n = 0; n < 4; n++) begin
        rd_word[8*n +: 8] = mem[{fetch_widx, 2'(n)}];
      end
    end
  end

  // Array write; reads above see the pre-edge contents (read-before-write).
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (load_be_i[n]) begin
          mem[{load_widx, 2'(n)}] <= load_data_i[8*n +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~rst_i;
        if (fetch_req_i && ready) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fetch_ready_o = ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_instr     <= RESET_INSTR;
      cap_fault     <= 2'b00;
      fetch_valid_o <= 1'b0;
      instruction_o <= RESET_INSTR;
      fault_o       <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_valid_o <= fire;
      if (accept) begin
        cap_instr <= rd_word;
        cap_fault <= {fetch_out_of_range, fetch_misaligned};
      end
      if (fire) begin
        instruction_o <= cap_instr;
        fault_o       <= cap_fault;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_memory_pipelined.sv
// ============================================================================
// Module   : tb_instruction_memory_pipelined
// Brief    : Scoreboard bench for instruction_memory_pipelined (latency 1..4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_memory_pipelined;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  logic        clk;
  logic        rst, req, ready, valid, we;
  logic [31:0] addr, instr, laddr, ldata;
  logic [1:0]  fault;
  logic [3:0]  be;

  logic        s_rst, s_req, s_we;
  logic [31:0] s_addr, s_laddr, s_ldata;
  logic [3:0]  s_be;
  logic        s_ready [4];
  logic        s_valid [4];
  logic [31:0] s_instr [4];
  logic [1:0]  s_fault [4];

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [7:0] model [1024];

  instruction_memory_pipelined #(.DEPTH_BYTES(1024), .ADDR_W(32), .READ_LATENCY(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(req), .fetch_addr_i(addr),
    .fetch_ready_o(ready), .fetch_valid_o(valid), .instruction_o(instr), .fault_o(fault),
    .load_we_i(we), .load_addr_i(laddr), .load_data_i(ldata), .load_be_i(be)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    instruction_memory_pipelined #(.DEPTH_BYTES(1024), .ADDR_W(32), .READ_LATENCY(k + 1)) u_sw (
      .clk_i(clk), .rst_i(s_rst), .fetch_req_i(s_req), .fetch_addr_i(s_addr),
      .fetch_ready_o(s_ready[k]), .fetch_valid_o(s_valid[k]), .instruction_o(s_instr[k]),
      .fault_o(s_fault[k]), .load_we_i(s_we), .load_addr_i(s_laddr), .load_data_i(s_ldata),
      .load_be_i(s_be)
    );
  end

  always #5 clk = ~clk;

  function automatic exp_t model_word(input logic [31:0] a);
    exp_t e;
    logic mis, oor;
    mis     = (a[1:0] != 2'b00);
    oor     = ({1'b0, a} > 33'd1020);
    e.fault = {oor, mis};
    if (mis || oor) e.instr = 32'h00000013;
    else e.instr = {model[a[9:0] + 10'd3], model[a[9:0] + 10'd2], model[a[9:0] + 10'd1], model[a[9:0]]};
    return e;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if ({1'b0, a} <= 33'd1020) begin
      for (int n = 0; n < 4; n++) if (b[n]) model[{a[9:2], 2'(n)}] = d[8*n +: 8];
    end
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; laddr = a; ldata = d; be = b;
    @(posedge clk);
    model_write(a, d, b);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic issue_fetch(input logic [31:0] a, output logic accepted);
    accepted = 1'b0;
    req = 1'b1; addr = a;
    for (int i = 0; i < 10 && !ready; i++) @(negedge clk);
    if (ready) begin
      sb.push_back(model_word(a));
      accepted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_valid(output logic seen, output int cyc);
    cyc = 0;
    while (!valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    seen = valid;
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h want=00000013", instr); end
    checks++; if (fault !== 2'b00) begin errors++; $display("FAIL reset_fault got=%b want=00", fault); end
    rst = 1'b0; s_rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b want=1", ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic acc, seen;
    int   lat;
    exp_t e;
    load_word(32'h0, 32'h00402103, 4'hF);
    issue_fetch(32'h0, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got=%b want=1", acc); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_busy_ready got=%b want=0", ready); end
    wait_valid(seen, lat);
    checks++; if (!seen || lat != 1) begin errors++; $display("FAIL single_latency got=%0d want=1", lat); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_back got=%b want=1", ready); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (instr !== e.instr) begin errors++; $display("FAIL single_instr got=%h want=%h", instr, e.instr); end
    checks++; if (instr !== 32'h00402103) begin errors++; $display("FAIL single_const got=%h want=00402103", instr); end
    checks++; if (fault !== 2'b00) begin errors++; $display("FAIL single_fault got=%b want=00", fault); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b want=0", valid); end
    checks++; if (instr !== 32'h00402103) begin errors++; $display("FAIL single_hold got=%h want=00402103", instr); end
  endtask

  task automatic test_byte_enables();
    logic acc, seen;
    int   lat;
    exp_t e;
    load_word(32'h18, 32'hAABBCCDD, 4'b1111);
    load_word(32'h18, 32'h11223344, 4'b0101);
    issue_fetch(32'h18, acc);
    wait_valid(seen, lat);
    checks++; if (!seen) begin errors++; $display("FAIL be_timeout got=0 want=1"); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (instr !== e.instr) begin errors++; $display("FAIL be_instr got=%h want=%h", instr, e.instr); end
    checks++; if (instr !== 32'hAA22CC44) begin errors++; $display("FAIL be_const got=%h want=AA22CC44", instr); end
  endtask

  task automatic test_faults();
    logic [31:0] fa [4];
    logic [1:0]  fe [4];
    logic acc, seen;
    int   lat;
    exp_t e;
    fa = '{32'h2, 32'h400, 32'h3FE, 32'h3FC};
    fe = '{2'b01, 2'b10, 2'b11, 2'b00};
    load_word(32'h3FC, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      issue_fetch(fa[i], acc);
      wait_valid(seen, lat);
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      checks++; if (!seen || fault !== fe[i]) begin errors++; $display("FAIL fault_code[%h] got=%b want=%b", fa[i], fault, fe[i]); end
      checks++; if (instr !== e.instr) begin errors++; $display("FAIL fault_instr[%h] got=%h want=%h", fa[i], instr, e.instr); end
    end
    checks++; if (instr !== 32'hDEADBEEF) begin errors++; $display("FAIL fault_last_word got=%h want=DEADBEEF", instr); end
  endtask

  task automatic test_collision();
    logic acc, seen;
    int   lat;
    exp_t e;
    load_word(32'h8, 32'h11111111, 4'hF);
    we = 1'b1; laddr = 32'h8; ldata = 32'h22222222; be = 4'hF;
    req = 1'b1; addr = 32'h8;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL coll_ready got=%b want=1", ready); end
    sb.push_back(model_word(32'h8));
    @(posedge clk);
    model_write(32'h8, 32'h22222222, 4'hF);
    @(negedge clk);
    we = 1'b0; req = 1'b0;
    wait_valid(seen, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (!seen || instr !== e.instr) begin errors++; $display("FAIL coll_old got=%h want=%h", instr, e.instr); end
    checks++; if (instr !== 32'h11111111) begin errors++; $display("FAIL coll_const got=%h want=11111111", instr); end
    issue_fetch(32'h8, acc);
    wait_valid(seen, lat);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++; if (!seen || instr !== e.instr) begin errors++; $display("FAIL coll_new got=%h want=%h", instr, e.instr); end
    checks++; if (instr !== 32'h22222222) begin errors++; $display("FAIL coll_new_const got=%h want=22222222", instr); end
  endtask

  task automatic test_latency_sweep();
    int acc_at [4];
    int last_acc [4];
    int nval [4];
    logic pending [4];
    for (int k = 0; k < 4; k++) begin acc_at[k] = 0; last_acc[k] = -1; nval[k] = 0; pending[k] = 1'b0; end
    s_addr = 32'h0; s_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (s_valid[k]) begin
          nval[k]++;
          checks++;
          if (!pending[k] || c - acc_at[k] != k + 1) begin
            errors++; $display("FAIL sweep_latency[L=%0d] got=%0d want=%0d", k + 1, c - acc_at[k], k + 1);
          end
          pending[k] = 1'b0;
        end
        if (s_ready[k] && s_req) begin
          if (last_acc[k] >= 0) begin
            checks++;
            if (c - last_acc[k] != k + 2) begin
              errors++; $display("FAIL sweep_spacing[L=%0d] got=%0d want=%0d", k + 1, c - last_acc[k], k + 2);
            end
          end
          last_acc[k] = c; acc_at[k] = c + 1; pending[k] = 1'b1;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (nval[k] < 5) begin errors++; $display("FAIL sweep_count[L=%0d] got=%0d want>=5", k + 1, nval[k]); end
    end
    s_req = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_fetch();
    logic any_valid, seen;
    s_we = 1'b1; s_laddr = 32'h10; s_ldata = 32'hCAFEF00D; s_be = 4'hF;
    @(negedge clk);
    s_we = 1'b0;
    s_addr = 32'h10; s_req = 1'b1;
    checks++; if (s_ready[2] !== 1'b1) begin errors++; $display("FAIL mid_ready_pre got=%b want=1", s_ready[2]); end
    @(negedge clk);
    s_req = 1'b0;
    s_rst = 1'b1;
    #1;
    checks++; if (s_ready[2] !== 1'b0) begin errors++; $display("FAIL mid_ready_rst got=%b want=0", s_ready[2]); end
    checks++; if (s_instr[2] !== 32'h13) begin errors++; $display("FAIL mid_instr_rst got=%h want=00000013", s_instr[2]); end
    s_we = 1'b1; s_laddr = 32'h20; s_ldata = 32'hFFFFFFFF; s_be = 4'hF;
    @(negedge clk);
    s_we = 1'b0;
    @(negedge clk);
    s_rst = 1'b0;
    #1;
    checks++; if (s_ready[2] !== 1'b1) begin errors++; $display("FAIL mid_ready_release got=%b want=1", s_ready[2]); end
    any_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (s_valid[k]) any_valid = 1'b1;
    end
    checks++; if (any_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid got=%b want=0", any_valid); end
    checks++; if (s_instr[2] !== 32'h13) begin errors++; $display("FAIL mid_instr_after got=%h want=00000013", s_instr[2]); end
    for (int t = 0; t < 2; t++) begin
      s_addr = (t == 0) ? 32'h10 : 32'h20; s_req = 1'b1;
      @(negedge clk);
      s_req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        seen = s_valid[2];
      end
      checks++;
      if (!seen || s_instr[2] !== ((t == 0) ? 32'hCAFEF00D : 32'h00000000)) begin
        errors++; $display("FAIL mid_mem[%0d] got=%h seen=%b want=%h", t, s_instr[2], seen,
                           (t == 0) ? 32'hCAFEF00D : 32'h00000000);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; s_rst = 1'b1;
    req = 1'b0; addr = '0; we = 1'b0; laddr = '0; ldata = '0; be = '0;
    s_req = 1'b0; s_addr = '0; s_we = 1'b0; s_laddr = '0; s_ldata = '0; s_be = '0;
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_byte_enables();
    test_faults();
    test_collision();
    test_latency_sweep();
    test_reset_mid_fetch();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
